// File: rtl/zipdiv_pkg.sv
// Shared types and helpers for the zipdiv_qr sequential divider.
package zipdiv_pkg;

  typedef enum logic [1:0] {IDLE, PRE, DIV, POST} div_state_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  // Number of DIV cycles for a given width and unroll factor.
  function automatic int div_iters(input int bw, input int steps);
    return bw / steps;
  endfunction

endpackage

// File: rtl/zipdiv_step.sv
// One combinational restoring shift-subtract step of the divider.
module zipdiv_step #(
  parameter int BW = 32
) (
  input  logic [BW:0]   r,
  input  logic [BW-1:0] q,
  input  logic [BW-1:0] d,
  output logic [BW:0]   r_nxt,
  output logic [BW-1:0] q_nxt
);

  logic [BW:0]   r_sh;
  logic [BW-1:0] q_sh;
  logic          unused_r_msb;

  // Partial remainder stays below D, so its top bit carries no information here.
  assign unused_r_msb = r[BW];
  assign r_sh = {r[BW-1:0], q[BW-1]};
  assign q_sh = {q[BW-2:0], 1'b0};

  always_comb begin
    r_nxt = r_sh;
    q_nxt = q_sh;
    if (r_sh >= {1'b0, d}) begin
      r_nxt = r_sh - {1'b0, d};
      q_nxt = {q_sh[BW-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/zipdiv_qr.sv
// Sequential signed/unsigned divider, STEPS quotient bits per clock.
// Optional cancel input enabled by defining ZIPDIV_ABORT_EN.
module zipdiv_qr
  import zipdiv_pkg::*;
#(
  parameter int BW    = 32,
  parameter int STEPS = 1,
  parameter int LGN   = $clog2(BW/STEPS+1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr,
  input  logic          i_signed,
  input  logic [BW-1:0] i_numerator,
  input  logic [BW-1:0] i_denominator,
`ifdef ZIPDIV_ABORT_EN
  input  logic          i_abort,
`endif
  output logic          o_busy,
  output logic          o_valid,
  output logic          o_err,
  output logic [BW-1:0] o_quotient,
  output logic [BW-1:0] o_remainder,
  output logic [3:0]    o_flags
);

  localparam int N = div_iters(BW, STEPS);
  localparam logic [BW-1:0] INT_MIN = {1'b1, {(BW-1){1'b0}}};

  div_state_t    state;
  logic [BW:0]   r;
  logic [BW-1:0] q, d;
  logic [LGN-1:0] cnt;
  logic          op_signed, q_neg, r_neg, ovf;
  logic [BW:0]   r_fin;
  logic [BW-1:0] q_fin, q_post, r_post;

  for (genvar i = 0; i < STEPS; i++) begin : g_step
    logic [BW:0]   r_i, r_o;
    logic [BW-1:0] q_i, q_o;
    if (i == 0) begin : g_first
      assign r_i = r;
      assign q_i = q;
    end else begin : g_next
      assign r_i = g_step[i-1].r_o;
      assign q_i = g_step[i-1].q_o;
    end
    zipdiv_step #(.BW(BW)) u_step (
      .r(r_i), .q(q_i), .d(d), .r_nxt(r_o), .q_nxt(q_o)
    );
  end

  assign r_fin  = g_step[STEPS-1].r_o;
  assign q_fin  = g_step[STEPS-1].q_o;
  assign q_post = q_neg ? -q : q;
  assign r_post = r_neg ? -r[BW-1:0] : r[BW-1:0];

  function automatic logic [3:0] flags_of(input logic [BW-1:0] qv, input logic [BW-1:0] rv,
                                          input logic v);
    logic [3:0] f;
    f = '0;
    f[FLAG_Z] = (qv == '0);
    f[FLAG_N] = qv[BW-1];
    f[FLAG_C] = (rv == '0);
    f[FLAG_V] = v;
    return f;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      o_busy      <= 1'b0;
      o_valid     <= 1'b0;
      o_err       <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
      o_flags     <= '0;
      cnt         <= '0;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      op_signed   <= 1'b0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_err   <= 1'b0;
`ifdef ZIPDIV_ABORT_EN
      if (i_abort && state != IDLE) begin
        state  <= IDLE;
        o_busy <= 1'b0;
      end else
`endif
      case (state)
        IDLE: if (i_wr) begin
          if (i_denominator == '0) begin
            o_valid     <= 1'b1;
            o_err       <= 1'b1;
            o_quotient  <= '0;
            o_remainder <= i_numerator;
            o_flags     <= 4'b0001;
          end else begin
            q         <= i_numerator;
            d         <= i_denominator;
            r         <= '0;
            cnt       <= LGN'(N);
            op_signed <= i_signed;
            ovf       <= 1'b0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            o_busy    <= 1'b1;
            state     <= i_signed ? PRE : DIV;
          end
        end
        PRE: begin
          q_neg <= q[BW-1] ^ d[BW-1];
          r_neg <= q[BW-1];
          q     <= q[BW-1] ? -q : q;
          d     <= d[BW-1] ? -d : d;
          // INT_MIN's magnitude already reads as 2^(BW-1) unsigned, so the
          // overflow quotient falls out of the normal datapath.
          ovf   <= (q == INT_MIN) && (&d);
          state <= DIV;
        end
        DIV: begin
          r   <= r_fin;
          q   <= q_fin;
          cnt <= cnt - LGN'(1);
          if (cnt == LGN'(1)) begin
            if (op_signed) begin
              state <= POST;
            end else begin
              o_quotient  <= q_fin;
              o_remainder <= r_fin[BW-1:0];
              o_flags     <= flags_of(q_fin, r_fin[BW-1:0], 1'b0);
              o_valid     <= 1'b1;
              o_busy      <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        POST: begin
          o_quotient  <= q_post;
          o_remainder <= r_post;
          o_flags     <= flags_of(q_post, r_post, ovf);
          o_valid     <= 1'b1;
          o_busy      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zipdiv_qr.sv
// Directed bench for zipdiv_qr: STEPS=1 and STEPS=4 instances side by side.
module tb_zipdiv_qr;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr, sg, wr4, sg4;
  logic [31:0] num, den, num4, den4;
  logic        busy, valid, err, busy4, valid4, err4;
  logic [31:0] quo, rem, quo4, rem4;
  logic [3:0]  flg, flg4;
`ifdef ZIPDIV_ABORT_EN
  logic        abort, abort4;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  zipdiv_qr #(.BW(32), .STEPS(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_wr(wr), .i_signed(sg),
    .i_numerator(num), .i_denominator(den),
`ifdef ZIPDIV_ABORT_EN
    .i_abort(abort),
`endif
    .o_busy(busy), .o_valid(valid), .o_err(err),
    .o_quotient(quo), .o_remainder(rem), .o_flags(flg)
  );

  zipdiv_qr #(.BW(32), .STEPS(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_wr(wr4), .i_signed(sg4),
    .i_numerator(num4), .i_denominator(den4),
`ifdef ZIPDIV_ABORT_EN
    .i_abort(abort4),
`endif
    .o_busy(busy4), .o_valid(valid4), .o_err(err4),
    .o_quotient(quo4), .o_remainder(rem4), .o_flags(flg4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns cycles from the i_wr cycle to the o_valid cycle.
  task automatic run1(input logic s, input logic [31:0] n, input logic [31:0] dd,
                      output int lat, output logic saw_busy);
    wr = 1'b1; sg = s; num = n; den = dd;
    @(negedge clk);
    wr = 1'b0; lat = 1; saw_busy = busy;
    while (!valid && lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy) saw_busy = 1'b1;
    end
    if (!valid) lat = -1;
  endtask

  task automatic go4(input logic [31:0] n, input logic [31:0] dd, input bit poke,
                     output int lat);
    wr4 = 1'b1; sg4 = 1'b0; num4 = n; den4 = dd;
    @(negedge clk);
    wr4 = 1'b0; lat = 1;
    while (!valid4 && lat < 100) begin
      @(negedge clk);
      lat++;
      if (poke && lat == 3) begin
        wr4 = 1'b1; num4 = 32'd7; den4 = 32'd0;
      end else wr4 = 1'b0;
    end
    if (!valid4) lat = -1;
  endtask

  task automatic res1(input string tag, input logic [31:0] q, input logic [31:0] r,
                      input logic e, input logic [3:0] f);
    chk({tag, ".q"}, 64'(quo), 64'(q));
    chk({tag, ".r"}, 64'(rem), 64'(r));
    chk({tag, ".err"}, 64'(err), 64'(e));
    chk({tag, ".flags"}, 64'(flg), 64'(f));
    chk({tag, ".busy_at_valid"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int lat, seen;
    logic sb;
    rst = 1'b1; wr = 1'b0; sg = 1'b0; num = '0; den = '0;
    wr4 = 1'b0; sg4 = 1'b0; num4 = '0; den4 = '0;
`ifdef ZIPDIV_ABORT_EN
    abort = 1'b0; abort4 = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.valid", 64'(valid), 64'd0);
    chk("rst.err", 64'(err), 64'd0);
    chk("rst.q", 64'(quo), 64'd0);
    chk("rst.r", 64'(rem), 64'd0);
    chk("rst.flags", 64'(flg), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run1(1'b0, 32'd100, 32'd7, lat, sb);
    chk("u100_7.lat", 64'(lat), 64'd33);
    res1("u100_7", 32'd14, 32'd2, 1'b0, 4'b0000);
    @(negedge clk);
    chk("u100_7.valid_pulse", 64'(valid), 64'd0);
    chk("u100_7.hold_q", 64'(quo), 64'd14);

    run1(1'b1, -32'sd100, 32'd7, lat, sb);
    chk("sn100_7.lat", 64'(lat), 64'd35);
    res1("sn100_7", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 4'b0100);
    @(negedge clk);

    run1(1'b1, 32'd100, -32'sd7, lat, sb);
    chk("s100_n7.lat", 64'(lat), 64'd35);
    res1("s100_n7", 32'hFFFF_FFF2, 32'd2, 1'b0, 4'b0100);
    @(negedge clk);

    run1(1'b0, 32'd12345, 32'd0, lat, sb);
    chk("udz.lat", 64'(lat), 64'd1);
    chk("udz.saw_busy", 64'(sb), 64'd0);
    res1("udz", 32'd0, 32'd12345, 1'b1, 4'b0001);
    @(negedge clk);
    chk("udz.err_pulse", 64'(err), 64'd0);

    run1(1'b1, 32'd12345, 32'd0, lat, sb);
    chk("sdz.lat", 64'(lat), 64'd1);
    chk("sdz.saw_busy", 64'(sb), 64'd0);
    res1("sdz", 32'd0, 32'd12345, 1'b1, 4'b0001);
    @(negedge clk);

    run1(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, sb);
    chk("ovf.lat", 64'(lat), 64'd35);
    res1("ovf", 32'h8000_0000, 32'd0, 1'b0, 4'b1110);
    @(negedge clk);

    run1(1'b0, 32'd5, 32'd7, lat, sb);
    res1("u5_7", 32'd0, 32'd5, 1'b0, 4'b0001);
    @(negedge clk);

    run1(1'b0, 32'hFFFF_FFFF, 32'd1, lat, sb);
    chk("umax_1.lat", 64'(lat), 64'd33);
    res1("umax_1", 32'hFFFF_FFFF, 32'd0, 1'b0, 4'b0110);
    @(negedge clk);

`ifdef ZIPDIV_ABORT_EN
    wr = 1'b1; sg = 1'b0; num = 32'd100; den = 32'd7;
    @(negedge clk);
    wr = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort.busy", 64'(busy), 64'd0);
    seen = 0;
    repeat (40) begin
      if (valid) seen++;
      @(negedge clk);
    end
    chk("abort.no_valid", 64'(seen), 64'd0);
    chk("abort.hold_q", 64'(quo), 64'hFFFF_FFFF);
`endif

    wr = 1'b1; sg = 1'b0; num = 32'd100; den = 32'd7;
    @(negedge clk);
    wr = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.busy", 64'(busy), 64'd0);
    seen = 0;
    repeat (40) begin
      if (valid) seen++;
      @(negedge clk);
    end
    chk("midrst.no_valid", 64'(seen), 64'd0);

    go4(32'd1000, 32'd10, 1'b1, lat);
    chk("s4_1000_10.lat", 64'(lat), 64'd9);
    chk("s4_1000_10.q", 64'(quo4), 64'd100);
    chk("s4_1000_10.r", 64'(rem4), 64'd0);
    chk("s4_1000_10.err", 64'(err4), 64'd0);
    chk("s4_1000_10.flags", 64'(flg4), 64'(4'b0010));
    chk("s4_1000_10.busy", 64'(busy4), 64'd0);
    // Back-to-back request issued in the o_valid cycle.
    go4(32'd50, 32'd7, 1'b0, lat);
    chk("s4_50_7.lat", 64'(lat), 64'd9);
    chk("s4_50_7.q", 64'(quo4), 64'd7);
    chk("s4_50_7.r", 64'(rem4), 64'd1);
    chk("s4_50_7.flags", 64'(flg4), 64'(4'b0000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
